gray_conv_arb: RTL and testbench
================================

GRAY_CONV_ARB -- requirements
Module: gray_conv_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the width of the binary operand and the Gray result.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the completed-conversion counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port req0_valid, input, 1 bit: requester 0 presents an operand.
REQ-006 The block SHALL have port req0_data, input, WIDTH bits: binary operand from requester 0.
REQ-007 The block SHALL have port req0_ready, output, 1 bit: requester 0 operand accepted this cycle.
REQ-008 The block SHALL have ports req1_valid, req1_data and req1_ready, identical in direction and width to the requester-0 ports, for requester 1.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result register holds a result.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: the registered Gray code.
REQ-011 The block SHALL have port out_src, output, 1 bit: the requester (0 or 1) that owns out_data.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 The block SHALL have port conv_count, output, CNT_W bits: number of results delivered.

Function
REQ-014 The block SHALL compute the conversion as gray[WIDTH-1] = bin[WIDTH-1] and gray[i] = bin[i+1] XOR bin[i] for i < WIDTH-1, in one shared converter instance.
REQ-015 The block SHALL implement a two-state FSM, EMPTY (out_valid = 0) and FULL (out_valid = 1), for the single-entry result register.
REQ-016 The block SHALL define can_accept = (state == EMPTY) OR (out_ready AND out_valid).
REQ-017 The block SHALL grant combinationally: with only one valid asserted, that requester wins; with both asserted, the requester other than last_grant wins.
REQ-018 The block SHALL assert reqN_ready only when requester N is granted and can_accept is 1, so at most one ready is high per cycle.
REQ-019 The block SHALL treat a transfer as reqN_valid AND reqN_ready; on a transfer it SHALL load out_data with the converted operand and out_src with N, and set last_grant to N.
REQ-020 The block SHALL present the result exactly 1 cycle after the accepting edge, with out_valid = 1 from the next cycle.
REQ-021 FSM transitions SHALL be:
- EMPTY to FULL on a transfer.
- FULL to EMPTY on out_ready with no transfer.
- FULL stays FULL on out_ready with a transfer (back-to-back, full throughput).
- FULL holds with out_data and out_src stable while out_ready = 0.
REQ-022 The block SHALL keep the readies independent of out_ready except through can_accept, and SHALL never drop or duplicate a result.
REQ-023 The block SHALL increment conv_count by 1 on each out_valid AND out_ready cycle, wrapping from 2^CNT_W-1 to 0.
REQ-024 The block SHALL guarantee that, with both requesters continuously valid and out_ready = 1, grants alternate 0,1,0,1,... with no requester waiting more than one transfer.
REQ-025 The block SHALL ignore reqN_data while reqN_valid = 0.

Reset
REQ-026 When rst_n = 0 at a rising edge, the block SHALL enter EMPTY and set out_valid = 0, out_data = 0, out_src = 0, conv_count = 0, and last_grant = 1, so requester 0 wins the first tie.
REQ-027 The block SHALL hold req0_ready = req1_ready = 0 during reset.
REQ-028 On reset mid-operation, the block SHALL discard any pending result without a handshake and leave conv_count at 0.

Verification
REQ-029 Single request: req0 sends 4'b1011 with out_ready = 1 -> req0_ready = 1 in that cycle; next cycle out_valid = 1, out_data = 4'b1110, out_src = 0; conv_count = 1 after the handshake.
REQ-030 Tie after reset: req0 = 4'b0110 and req1 = 4'b1111 both valid -> req0 is served first (out_data = 4'b0101, src 0), then req1 (4'b1000, src 1), in consecutive cycles.
REQ-031 Backpressure: out_ready = 0 for 5 cycles while FULL -> out_data stable, both readies 0; on out_ready = 1 the next operand is accepted in that same cycle.
REQ-032 Fairness: both requesters valid for 8 cycles with out_ready = 1 -> out_src sequence is 0,1,0,1,0,1,0,1 and conv_count = 8.
REQ-033 Wrap and reset: conv_count = 255 plus one handshake -> 0; assert rst_n = 0 while FULL -> out_valid = 0 on the next cycle, and the next tie goes to req0.

Source files
------------

// File: rtl/gray_conv_arb.sv
// gray_conv_arb: two-requester round-robin arbiter in front of one shared
// binary-to-Gray converter, with a single-entry registered result stage.
//
// Parameters
//   WIDTH  - width of the binary operand and the Gray result
//   CNT_W  - width of the delivered-result counter
//
// Ports
//   clk          - clock, all state updates on the rising edge
//   rst_n        - synchronous active-low reset
//   reqN_valid   - requester N presents an operand (N = 0, 1)
//   reqN_data    - binary operand from requester N
//   reqN_ready   - requester N operand accepted this cycle
//   out_valid    - result register holds a result
//   out_data     - registered Gray code
//   out_src      - requester that owns out_data
//   out_ready    - consumer takes the result this cycle
//   conv_count   - number of results delivered (wraps)
module gray_conv_arb #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] conv_count
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic [CNT_W-1:0] conv_count_q, conv_count_d;

    logic             grant_sel;
    logic             can_accept;
    logic             xfer;
    logic             handshake;
    logic [WIDTH-1:0] conv_bin;
    logic [WIDTH-1:0] conv_gray;

    assign out_valid  = (state_q == FULL);
    assign out_data   = out_data_q;
    assign out_src    = out_src_q;
    assign conv_count = conv_count_q;

    // The slot can take a new operand when empty, or when the current result
    // leaves this very cycle (full throughput).
    assign can_accept = (state_q == EMPTY) | (out_ready & out_valid);
    assign handshake  = out_valid & out_ready;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = req1_valid;
        end
    end

    // Readies are forced low while reset is asserted.
    assign req0_ready = rst_n & can_accept & req0_valid & ~grant_sel;
    assign req1_ready = rst_n & can_accept & req1_valid & grant_sel;
    assign xfer       = req0_ready | req1_ready;

    // Single converter shared by both requesters.
    assign conv_bin = grant_sel ? req1_data : req0_data;

    always_comb begin
        conv_gray = '0;
        conv_gray[WIDTH-1] = conv_bin[WIDTH-1];
        for (int i = 0; i < int'(WIDTH) - 1; i++) begin
            conv_gray[i] = conv_bin[i+1] ^ conv_bin[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        conv_count_d = conv_count_q + {{(CNT_W-1){1'b0}}, handshake};

        case (state_q)
            EMPTY: begin
                if (xfer) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (xfer) begin
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (xfer) begin
            out_data_d   = conv_gray;
            out_src_d    = grant_sel;
            last_grant_d = grant_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
            out_data_q   <= '0;
            out_src_q    <= 1'b0;
            conv_count_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            conv_count_q <= conv_count_d;
        end
    end

endmodule

// File: tb/tb_gray_conv_arb.sv
// Scoreboard bench for gray_conv_arb: the stimulus pushes hand-computed
// expected results; a negedge monitor pops and compares on every handshake.
module tb_gray_conv_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_src;
    logic       out_ready;
    logic [7:0] conv_count;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];
    logic [4:0] mon_e;

    always #5 clk = ~clk;

    gray_conv_arb #(
        .WIDTH(4),
        .CNT_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .conv_count(conv_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Monitor: every delivered result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got src %0d data %0h expected none",
                         out_src, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_src", 32'(out_src), 32'(mon_e[4]));
                chk("out_data", 32'(out_data), 32'(mon_e[3:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 4'h0;
        req1_data  = 4'h0;
        out_ready  = 1'b0;

        // Reset state, readies held low even with a valid request.
        step();
        step();
        req0_valid = 1'b1;
        req0_data  = 4'hF;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_count", 32'(conv_count), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        rst_n      = 1'b1;

        // Single request: 1011 -> 1110.
        out_ready  = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 4'b1011;
        exp_q.push_back({1'b0, 4'b1110});
        @(negedge clk);
        chk("single_req0_ready", 32'(req0_ready), 32'd1);
        chk("single_req1_ready", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        req0_data  = 4'hA;
        @(negedge clk);
        chk("single_out_valid", 32'(out_valid), 32'd1);
        step();
        chk("single_count", 32'(conv_count), 32'd1);

        // Tie after reset: req0 first, then req1.
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 4'b0110;
        req1_valid = 1'b1;
        req1_data  = 4'b1111;
        exp_q.push_back({1'b0, 4'b0101});
        exp_q.push_back({1'b1, 4'b1000});
        @(negedge clk);
        chk("tie_req0_ready", 32'(req0_ready), 32'd1);
        chk("tie_req1_ready_low", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("tie_req1_ready", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        step();
        step();
        chk("tie_count", 32'(conv_count), 32'd2);

        // Backpressure: result held for 5 cycles, then next operand accepted
        // in the same cycle out_ready rises.
        out_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 4'b0011;
        exp_q.push_back({1'b0, 4'b0010});
        @(negedge clk);
        chk("bp_req0_ready", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 4'b0101;
        exp_q.push_back({1'b1, 4'b0111});
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'b0010);
            chk("bp_req0_ready", 32'(req0_ready), 32'd0);
            chk("bp_req1_ready", 32'(req1_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_req1_ready", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        step();
        chk("bp_count", 32'(conv_count), 32'd4);

        // Fairness: both valid for 8 cycles, strict alternation from req0.
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 4'b0001;
        req1_valid = 1'b1;
        req1_data  = 4'b1000;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({i[0], (i[0] ? 4'b1100 : 4'b0001)});
            @(negedge clk);
            chk("fair_req0_ready", 32'(req0_ready), 32'(!i[0]));
            chk("fair_req1_ready", 32'(req1_ready), 32'(i[0]));
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        step();
        chk("fair_count", 32'(conv_count), 32'd8);

        // Counter wrap: 247 more results bring the count to 255, one more to 0.
        req0_valid = 1'b1;
        for (int i = 0; i < 247; i++) begin
            logic [3:0] b;
            b = 4'(i);
            req0_data = b;
            exp_q.push_back({1'b0, b ^ (b >> 1)});
            @(negedge clk);
            chk("bulk_req0_ready", 32'(req0_ready), 32'd1);
            step();
        end
        req0_valid = 1'b0;
        @(negedge clk);
        step();
        chk("count_255", 32'(conv_count), 32'd255);
        req0_valid = 1'b1;
        req0_data  = 4'b1010;
        exp_q.push_back({1'b0, 4'b1111});
        @(negedge clk);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        step();
        chk("count_wrap", 32'(conv_count), 32'd0);

        // Reset while FULL discards the pending result; next tie goes to req0.
        out_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 4'b0111;
        @(negedge clk);
        chk("rf_req0_ready", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("rf_full", 32'(out_valid), 32'd1);
        step();
        rst_n = 1'b0;
        step();
        chk("rf_out_valid", 32'(out_valid), 32'd0);
        chk("rf_count", 32'(conv_count), 32'd0);
        chk("rf_out_data", 32'(out_data), 32'd0);
        rst_n      = 1'b1;
        out_ready  = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 4'b1100;
        req1_valid = 1'b1;
        req1_data  = 4'b0011;
        exp_q.push_back({1'b0, 4'b1010});
        exp_q.push_back({1'b1, 4'b0010});
        @(negedge clk);
        chk("rf_tie_req0_ready", 32'(req0_ready), 32'd1);
        chk("rf_tie_req1_ready", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("rf_req1_ready", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        step();
        step();
        chk("rf_final_count", 32'(conv_count), 32'd2);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
